// File: rtl/instr_fetch_queue_pkg.sv
// instr_fetch_queue_pkg: shared defaults, fetch-entry type and pointer-width helper
package instr_fetch_queue_pkg;
    localparam int IFQ_DEPTH_DEF = 4;
    localparam int IFQ_AW_DEF = 32;
    localparam int IFQ_DW_DEF = 32;
    typedef struct packed {
        logic [IFQ_AW_DEF-1:0] pc;
        logic [IFQ_DW_DEF-1:0] instr;
    } fetch_entry_t;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// ifq_fifo: power-of-two {pc,instr} queue with wrapping pointers, occupancy count and clear
module ifq_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEF,
    parameter int W = IFQ_AW_DEF + IFQ_DW_DEF,
    localparam int PW = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [PW:0]   count
);
    localparam int CW = PW + 1;
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end
    assign rdata = (|count) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: PC-driven fetch stage feeding decode through a {pc,instr} queue with flush and back-pressure
// IFQ_PERF_CNT_EN adds saturating stall/flush counters; without it both counter ports read 0.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEF,
    parameter int AW = IFQ_AW_DEF,
    parameter int DW = IFQ_DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc_in,
    output logic          pc_hold,
    input  logic          flush,
    output logic          imem_en,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt
);
    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 2;
    logic [PW:0] count;
    logic inflight_v;
    logic [AW-1:0] inflight_pc;
    logic issue;
    logic push;
    logic pop;
    logic [AW+DW-1:0] head;
    assign out_valid = (|count) && !flush;
    assign pop = out_valid && out_ready;
    assign push = inflight_v && !flush;
    // a pop frees its slot this cycle, so it raises the limit instead of lowering occupancy
    assign issue = !flush && (CW'(count) + CW'(inflight_v) < CW'(DEPTH) + CW'(pop));
    assign imem_en = issue;
    assign imem_addr = pc_in;
    assign pc_hold = !issue;
    assign {out_pc, out_instr} = head;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_v <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight_v <= issue;
            if (issue) inflight_pc <= pc_in;
        end
    end
    ifq_fifo #(.DEPTH(DEPTH), .W(AW + DW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({inflight_pc, imem_rdata}),
        .rdata (head),
        .count (count)
    );
`ifdef IFQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_hold && !flush && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
            if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: scoreboard bench; a reference model predicts issue/valid and queues expected entries
module tb_instr_fetch_queue;
    import instr_fetch_queue_pkg::*;
    localparam int DEPTH = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [AW-1:0] pc_in = '0;
    logic pc_hold;
    logic flush = 1'b0;
    logic imem_en;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    int checks = 0;
    int failures = 0;
    fetch_entry_t sb[$];
    logic m_inf = 1'b0;
    logic [AW-1:0] m_inf_pc = '0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_in      (pc_in),
        .pc_hold    (pc_hold),
        .flush      (flush),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    always @(posedge clk) if (imem_en) imem_rdata <= mem_word(imem_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // called at a falling edge; drives inputs, checks, advances the model past the next rising edge
    task automatic cycle(input logic rdy, input logic fl);
        logic vld, pop, iss;
        out_ready = rdy;
        flush = fl;
        #1;
        vld = (sb.size() != 0) && !fl;
        pop = vld && rdy;
        iss = !fl && (sb.size() + int'(m_inf) - int'(pop) < DEPTH);
        check("out_valid", out_valid, vld);
        check("pc_hold", pc_hold, !iss);
        check("imem_en", imem_en, iss);
        if (iss) check("imem_addr", imem_addr, pc_in);
        if (vld) begin
            check("out_pc", out_pc, sb[0].pc);
            check("out_instr", out_instr, sb[0].instr);
        end else if (sb.size() == 0) begin
            check("empty_out_pc", out_pc, 0);
        end
        if (fl) begin
            sb.delete();
            m_inf = 1'b0;
            m_flush++;
        end else begin
            if (pop) void'(sb.pop_front());
            if (m_inf) sb.push_back('{pc: m_inf_pc, instr: mem_word(m_inf_pc)});
            if (!iss) m_stall++;
            m_inf = iss;
            m_inf_pc = pc_in;
        end
        @(negedge clk);
        if (iss) pc_in = pc_in + 1;
    endtask

    // asserted between edges to exercise the asynchronous path; returns at a falling edge
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_instr", out_instr, 0);
        sb.delete();
        m_inf = 1'b0;
        m_stall = 0;
        m_flush = 0;
        pc_in = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("rst_imem_en", imem_en, 1);
        check("rst_pc_hold", pc_hold, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        pc_in = 32'h20;
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        #1;
`ifdef IFQ_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 10);
        check("flush_cnt", flush_cnt, 2);
`else
        check("stall_cnt_off", stall_cnt, 0);
        check("flush_cnt_off", flush_cnt, 0);
`endif
        @(negedge clk);
        for (int i = 0; i < 400; i++) begin
            logic fl;
            fl = ($urandom_range(0, 19) == 0);
            if (fl) pc_in = AW'($urandom_range(0, 255));
            cycle($urandom_range(0, 3) != 0, fl);
        end
        #1;
`ifdef IFQ_PERF_CNT_EN
        check("stall_cnt_rand", stall_cnt, 32'(m_stall));
        check("flush_cnt_rand", flush_cnt, 32'(m_flush));
`else
        check("stall_cnt_rand_off", stall_cnt, 0);
        check("flush_cnt_rand_off", flush_cnt, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
